// File: rtl/xentry_types.sv
// Shared types for the L2 request interface and the main-memory responder.
//   memory_operation_e : request opcode on req_type. Only LOAD and STORE do
//                        anything; the other encodings are fulfilled as no-ops.
//   responder_state_e  : main_memory_responder FSM encoding, exported so a
//                        bench can name the states.
package xentry_types;

  typedef enum logic [1:0] {
    MEM_NOP  = 2'b00,
    LOAD     = 2'b01,
    STORE    = 2'b10,
    MEM_RSVD = 2'b11
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_RESPOND  = 2'b10,
    ST_COOLDOWN = 2'b11
  } responder_state_e;

endpackage

// File: rtl/word_memory_array.sv
// MEM_WORDS x XLEN word store backing main_memory_responder.
//   clk   : write clock
//   we    : write enable, write lands on the rising edge
//   waddr : word index for the write
//   wdata : write data
//   raddr : word index for the read
//   rdata : combinational read data
// The array has no reset; its contents survive responder resets and start
// at zero.
module word_memory_array #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [MEM_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model at the far end of the L2 request interface.
// One request is handled at a time: it is latched on acceptance, serviced
// ACCESS_LATENCY cycles later with a one-cycle req_fulfilled pulse, and then
// a single cooldown cycle ignores req_valid so a still-held valid is not
// serviced twice.
//   clk, reset    : clock; synchronous active-high reset
//   req_address   : byte address; word index is [$clog2(MEM_WORDS)+1:2]
//   req_type      : LOAD / STORE; other encodings complete without effect
//   req_valid     : request present, held by the requester until fulfilled
//   word_to_store : store data
//   fetched_word  : load data, non-zero only in the fulfil cycle of a LOAD
//   req_fulfilled : one-cycle completion pulse
//   busy          : high whenever the FSM is not idle
module main_memory_responder
  import xentry_types::*;
#(
  parameter int XLEN           = 32,
  parameter int MEM_WORDS      = 1024,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   req_address,
  input  memory_operation_e req_type,
  input  logic              req_valid,
  input  logic [XLEN-1:0]   word_to_store,
  output logic [XLEN-1:0]   fetched_word,
  output logic              req_fulfilled,
  output logic              busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(ACCESS_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_LATENCY - 1);

  responder_state_e  state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     lat_idx;
  memory_operation_e lat_op;
  logic [XLEN-1:0]   lat_data;

  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     rd_idx;
  logic [XLEN-1:0]   rd_data;
  logic              mem_we;

  // Alignment bits and bits above the array size are deliberately dropped,
  // so addresses alias modulo MEM_WORDS.
  assign req_idx = req_address[AW+1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_address[XLEN-1:AW+2], req_address[1:0]};

  // With ACCESS_LATENCY=1 the response is produced on the acceptance edge,
  // before lat_idx holds the new index, so read from the live request then.
  assign rd_idx = (state == ST_IDLE) ? req_idx : lat_idx;

  // Store commits at the end of the respond cycle; reset wins.
  assign mem_we = (state == ST_RESPOND) && (lat_op == STORE) && !reset;

  word_memory_array #(.XLEN(XLEN), .MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (lat_idx),
    .wdata (lat_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lat_idx       <= '0;
      lat_op        <= MEM_NOP;
      lat_data      <= '0;
      req_fulfilled <= 1'b0;
      fetched_word  <= '0;
    end else begin
      req_fulfilled <= 1'b0;
      fetched_word  <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_idx  <= req_idx;
            lat_op   <= req_type;
            lat_data <= word_to_store;
            cnt      <= CNT_LOAD;
            if (ACCESS_LATENCY == 1) begin
              state         <= ST_RESPOND;
              req_fulfilled <= 1'b1;
              if (req_type == LOAD) fetched_word <= rd_data;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state         <= ST_RESPOND;
            req_fulfilled <= 1'b1;
            if (lat_op == LOAD) fetched_word <= rd_data;
          end
        end
        ST_RESPOND:  state <= ST_COOLDOWN;
        ST_COOLDOWN: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;
  import xentry_types::*;

  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       req_address = '0;
  memory_operation_e req_type = MEM_NOP;
  logic              req_valid = 1'b0;
  logic [31:0]       word_to_store = '0;
  logic [31:0]       fetched_word;
  logic              req_fulfilled;
  logic              busy;

  // latency-1 instance
  logic [31:0]       l1_address = '0;
  memory_operation_e l1_type = MEM_NOP;
  logic              l1_valid = 1'b0;
  logic [31:0]       l1_store = '0;
  logic [31:0]       l1_fetched;
  logic              l1_fulfilled;
  logic              l1_busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  main_memory_responder #(.XLEN(32), .MEM_WORDS(1024), .ACCESS_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_address(req_address), .req_type(req_type),
    .req_valid(req_valid), .word_to_store(word_to_store),
    .fetched_word(fetched_word), .req_fulfilled(req_fulfilled), .busy(busy)
  );

  main_memory_responder #(.XLEN(32), .MEM_WORDS(1024), .ACCESS_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_address(l1_address), .req_type(l1_type),
    .req_valid(l1_valid), .word_to_store(l1_store),
    .fetched_word(l1_fetched), .req_fulfilled(l1_fulfilled), .busy(l1_busy)
  );

  // Drives one request on u_dut and observes it through the cooldown cycle.
  // Returns the cycle (1 = first cycle after acceptance) of the first pulse,
  // the pulse count, fetched_word during the pulse and the number of
  // non-pulse cycles with a non-zero fetched_word. Ends on the cooldown
  // cycle's falling edge.
  task automatic txn(input memory_operation_e op, input logic [31:0] addr,
                     input logic [31:0] data, output int ful, output int pulses,
                     output logic [31:0] word, output int stray);
    @(negedge clk);
    req_valid = 1'b1; req_type = op; req_address = addr; word_to_store = data;
    ful = -1; pulses = 0; word = '0; stray = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (req_fulfilled) begin
        pulses++;
        if (ful < 0) begin ful = k; word = fetched_word; end
      end else if (fetched_word != 0) begin
        stray++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (req_fulfilled !== 1'b0) begin mismatched++; $display("FAIL reset_fulfilled got %0b want 0", req_fulfilled); end
    compared++; if (fetched_word !== 32'h0) begin mismatched++; $display("FAIL reset_fetched got %h want 0", fetched_word); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy); end
    compared++; if (l1_busy !== 1'b0) begin mismatched++; $display("FAIL reset_l1_busy got %0b want 0", l1_busy); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    int ful, pulses, stray;
    logic [31:0] w;
    txn(STORE, 32'h0000_0010, 32'hDEAD_BEEF, ful, pulses, w, stray);
    compared++; if (ful !== LAT) begin mismatched++; $display("FAIL store_latency got %0d want %0d", ful, LAT); end
    compared++; if (pulses !== 1) begin mismatched++; $display("FAIL store_pulses got %0d want 1", pulses); end
    compared++; if (w !== 32'h0) begin mismatched++; $display("FAIL store_fetched got %h want 0", w); end
    txn(LOAD, 32'h0000_0010, 32'h0, ful, pulses, w, stray);
    compared++; if (ful !== LAT) begin mismatched++; $display("FAIL load_latency got %0d want %0d", ful, LAT); end
    compared++; if (pulses !== 1) begin mismatched++; $display("FAIL load_pulses got %0d want 1", pulses); end
    compared++; if (w !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL load_data got %h want deadbeef", w); end
    compared++; if (stray !== 0) begin mismatched++; $display("FAIL load_stray got %0d want 0", stray); end
  endtask

  task automatic test_back_to_back();
    int ful, pulses, stray, waited;
    logic [31:0] w;
    txn(STORE, 32'h0000_0020, 32'hCAFE_F00D, ful, pulses, w, stray);
    @(negedge clk);
    req_valid = 1'b1; req_type = LOAD; req_address = 32'h0000_0020;
    // k counts falling edges after the first acceptance edge; period 6
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      compared++;
      if (req_fulfilled !== (k % 6 == 4)) begin
        mismatched++; $display("FAIL b2b_fulfilled k=%0d got %0b want %0b", k, req_fulfilled, (k % 6 == 4));
      end
      compared++;
      if (busy !== (k % 6 != 0)) begin
        mismatched++; $display("FAIL b2b_busy k=%0d got %0b want %0b", k, busy, (k % 6 != 0));
      end
      compared++;
      if (fetched_word !== ((k % 6 == 4) ? 32'hCAFE_F00D : 32'h0)) begin
        mismatched++; $display("FAIL b2b_fetched k=%0d got %h", k, fetched_word);
      end
    end
    req_valid = 1'b0;
    waited = 0;
    while (busy && waited < 12) begin @(negedge clk); waited++; end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got busy=%0b want 0", busy); end
  endtask

  task automatic test_input_change();
    int ful, pulses, stray;
    logic [31:0] w;
    @(negedge clk);
    req_valid = 1'b1; req_type = STORE; req_address = 32'h0000_0004; word_to_store = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0; req_type = LOAD; req_address = 32'h0000_0008; word_to_store = 32'h2222_2222;
    repeat (LAT) @(negedge clk);
    txn(LOAD, 32'h0000_0004, 32'h0, ful, pulses, w, stray);
    compared++; if (w !== 32'h1111_1111) begin mismatched++; $display("FAIL chg_word1 got %h want 11111111", w); end
    txn(LOAD, 32'h0000_0008, 32'h0, ful, pulses, w, stray);
    compared++; if (w !== 32'h0) begin mismatched++; $display("FAIL chg_word2 got %h want 0", w); end
    // reserved opcode: still fulfilled, memory untouched
    txn(MEM_RSVD, 32'h0000_0004, 32'hFFFF_FFFF, ful, pulses, w, stray);
    compared++; if (ful !== LAT) begin mismatched++; $display("FAIL nop_latency got %0d want %0d", ful, LAT); end
    compared++; if (w !== 32'h0) begin mismatched++; $display("FAIL nop_fetched got %h want 0", w); end
    txn(LOAD, 32'h0000_0007, 32'h0, ful, pulses, w, stray);
    compared++; if (w !== 32'h1111_1111) begin mismatched++; $display("FAIL nop_untouched got %h want 11111111", w); end
  endtask

  task automatic test_alias();
    int ful, pulses, stray;
    logic [31:0] w;
    txn(STORE, 32'h0000_1000, 32'hA5A5_A5A5, ful, pulses, w, stray);
    txn(LOAD, 32'h0000_0002, 32'h0, ful, pulses, w, stray);
    compared++; if (w !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL alias_word0 got %h want a5a5a5a5", w); end
  endtask

  task automatic test_reset_mid();
    int ful, pulses, stray, seen;
    logic [31:0] w;
    @(negedge clk);
    req_valid = 1'b1; req_type = STORE; req_address = 32'h0000_0008; word_to_store = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    compared++; if (req_fulfilled !== 1'b0) begin mismatched++; $display("FAIL rst_mid_fulfilled got %0b want 0", req_fulfilled); end
    compared++; if (fetched_word !== 32'h0) begin mismatched++; $display("FAIL rst_mid_fetched got %h want 0", fetched_word); end
    seen = 0;
    repeat (LAT + 2) begin @(negedge clk); if (req_fulfilled) seen++; end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL rst_mid_pulse got %0d pulses want 0", seen); end
    txn(LOAD, 32'h0000_0008, 32'h0, ful, pulses, w, stray);
    compared++; if (w !== 32'h0) begin mismatched++; $display("FAIL rst_mid_word got %h want 0", w); end
  endtask

  task automatic test_latency1();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      l1_valid = 1'b1; l1_address = 32'h0000_0000;
      l1_type = (t == 0) ? STORE : LOAD;
      l1_store = 32'h5A5A_0001;
      @(negedge clk);
      l1_valid = 1'b0;
      compared++;
      if (l1_fulfilled !== 1'b1) begin mismatched++; $display("FAIL lat1_fulfilled t=%0d got %0b want 1", t, l1_fulfilled); end
      compared++;
      if (l1_fetched !== ((t == 1) ? 32'h5A5A_0001 : 32'h0)) begin
        mismatched++; $display("FAIL lat1_fetched t=%0d got %h", t, l1_fetched);
      end
      @(negedge clk);
      compared++;
      if (l1_fulfilled !== 1'b0) begin mismatched++; $display("FAIL lat1_single t=%0d got %0b want 0", t, l1_fulfilled); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_input_change();
    test_alias();
    test_reset_mid();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
